// File: rtl/traffic_gen_pe.sv
// Mesh traffic-generator processing element: injects timestamped packets toward its router
// and collects delivery statistics (count, latency sum/max, misroute flag) from it.
module traffic_gen_pe #(
    parameter int unsigned X          = 4,
    parameter int unsigned Y          = 4,
    parameter int unsigned x_size     = $clog2(X),
    parameter int unsigned y_size     = $clog2(Y),
    parameter int unsigned data_width = 256,
    parameter int unsigned MY_X       = 0,
    parameter int unsigned MY_Y       = 0,
    parameter int unsigned numPackets = 1000,
    parameter int unsigned rate       = 32,
    parameter int unsigned PATTERN    = 0,
    parameter int unsigned HOT_X      = 0,
    parameter int unsigned HOT_Y      = 0,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic                                  enableSend,
    output logic                                  r_valid_pe,
    output logic [x_size+y_size+data_width-1:0]   r_data_pe,
    input  logic                                  r_ready_pe,
    input  logic                                  w_valid_pe,
    input  logic [x_size+y_size+data_width-1:0]   w_data_pe,
    output logic                                  done,
    output logic [31:0]                           sentCount,
    output logic [31:0]                           receiveCount,
    output logic [47:0]                           latencySum,
    output logic [31:0]                           latencyMax,
    output logic                                  misroute
);

    localparam int unsigned T   = x_size + y_size + data_width;
    localparam int unsigned TSB = x_size + y_size;

    localparam logic [15:0] SEED_MIX  = SEED ^ 16'(MY_Y * X + MY_X);
    localparam logic [15:0] LFSR_INIT = (SEED_MIX == 16'd0) ? 16'd1 : SEED_MIX;

    typedef enum logic [1:0] {StIdle, StWait, StSend, StDone} state_e;

    state_e        state_q, state_d;
    logic [31:0]   period_q, period_d;
    logic [31:0]   cycle_count_q;
    logic [15:0]   lfsr_q;
    logic [31:0]   sent_q;
    logic [T-1:0]  data_q;
    logic          load;
    logic          handshake;
    logic          go;

    logic [31:0]   recv_q;
    logic [47:0]   lat_sum_q;
    logic [31:0]   lat_max_q;
    logic          misroute_q;

    // ------------------------------------------------------------------
    // Destination selection
    // ------------------------------------------------------------------
    int unsigned       ux, uy;
    logic [x_size-1:0] dest_x;
    logic [y_size-1:0] dest_y;

    always_comb begin
        ux = 32'(lfsr_q[x_size-1:0]);
        uy = 32'(lfsr_q[8 +: y_size]);
        if (ux >= X) ux = ux - X;
        if (uy >= Y) uy = uy - Y;
        if (ux == MY_X && uy == MY_Y) ux = (ux + 1 >= X) ? 0 : ux + 1;
        if (PATTERN == 1) begin
            ux = MY_Y;
            uy = MY_X;
        end else if (PATTERN == 2) begin
            ux = X - 1 - MY_X;
            uy = Y - 1 - MY_Y;
        end else if (PATTERN == 3) begin
            ux = HOT_X;
            uy = HOT_Y;
        end
        dest_x = x_size'(ux);
        dest_y = y_size'(uy);
    end

    // Timestamp is the cycleCount value seen during the first SEND cycle, i.e. the
    // counter value right after the loading edge.
    logic [T-1:0] pkt;

    always_comb begin
        pkt                    = '0;
        pkt[x_size-1:0]        = dest_x;
        pkt[x_size +: y_size]  = dest_y;
        pkt[TSB +: 32]         = cycle_count_q + 32'd1;
        pkt[TSB + 32 +: 16]    = sent_q[15:0];
    end

    // ------------------------------------------------------------------
    // Injection FSM
    // ------------------------------------------------------------------
    assign go = start & enableSend;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        load      = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d  = StWait;
                    period_d = 32'd0;
                end
            end
            StWait: begin
                if (!go) begin
                    state_d = StIdle;
                end else if (period_q == 32'(rate - 1)) begin
                    state_d = StSend;
                    load    = 1'b1;
                end else begin
                    period_d = period_q + 32'd1;
                end
            end
            StSend: begin
                // Valid is never withdrawn here; only the handshake leaves SEND.
                if (r_ready_pe) begin
                    handshake = 1'b1;
                    if (sent_q + 32'd1 == 32'(numPackets)) begin
                        state_d = StDone;
                    end else if (go) begin
                        state_d  = StWait;
                        period_d = 32'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            period_q      <= 32'd0;
            cycle_count_q <= 32'd0;
            lfsr_q        <= LFSR_INIT;
            sent_q        <= 32'd0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            cycle_count_q <= cycle_count_q + 32'd1;
            if (load) data_q <= pkt;
            if (handshake) begin
                sent_q <= sent_q + 32'd1;
                lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end
        end
    end

    assign r_valid_pe = (state_q == StSend);
    assign r_data_pe  = data_q;
    assign done       = (state_q == StDone);
    assign sentCount  = sent_q;

    // ------------------------------------------------------------------
    // Receive statistics (independent of the FSM)
    // ------------------------------------------------------------------
    logic [31:0] rx_ts;
    logic [31:0] lat;
    logic [48:0] sum_ext;
    logic        rx_wrong_dest;
    logic        unused_rx_payload;

    assign rx_ts             = w_data_pe[TSB +: 32];
    assign lat               = cycle_count_q - rx_ts;
    assign sum_ext           = {1'b0, lat_sum_q} + 49'(lat);
    assign rx_wrong_dest     = (w_data_pe[x_size-1:0] != x_size'(MY_X)) ||
                               (w_data_pe[x_size +: y_size] != y_size'(MY_Y));
    assign unused_rx_payload = ^w_data_pe[T-1:TSB+32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            recv_q     <= 32'd0;
            lat_sum_q  <= 48'd0;
            lat_max_q  <= 32'd0;
            misroute_q <= 1'b0;
        end else if (w_valid_pe) begin
            if (recv_q != 32'hFFFF_FFFF) recv_q <= recv_q + 32'd1;
            lat_sum_q <= sum_ext[48] ? 48'hFFFF_FFFF_FFFF : sum_ext[47:0];
            if (lat > lat_max_q) lat_max_q <= lat;
            if (rx_wrong_dest) misroute_q <= 1'b1;
        end
    end

    assign receiveCount = recv_q;
    assign latencySum   = lat_sum_q;
    assign latencyMax   = lat_max_q;
    assign misroute     = misroute_q;

endmodule

// File: tb/tb_traffic_gen_pe.sv
// Bench for traffic_gen_pe: two instances (random pattern with random backpressure and
// receive traffic; bit-complement burst) checked against a behavioural model every cycle.
module tb_traffic_gen_pe;

    localparam int unsigned RATE_A = 3;
    localparam int unsigned NPK_A  = 1000;
    localparam int unsigned RATE_B = 1;
    localparam int unsigned NPK_B  = 4;
    localparam logic [3:0]  SELF_A = 4'd9;   // (x=1, y=2) packed as y*4+x
    localparam longint unsigned SUM_MAX = 64'h0000_FFFF_FFFF_FFFF;

    logic clk, rstn, start;
    logic en_a, rdy_a, va, wv_a, done_a, mis_a;
    logic [67:0] da, wd_a;
    logic [31:0] sent_a, recv_a, max_a;
    logic [47:0] sum_a;
    logic en_b, rdy_b, vb, wv_b, done_b, mis_b;
    logic [51:0] db, wd_b;
    logic [31:0] sent_b, recv_b, max_b;
    logic [47:0] sum_b;

    traffic_gen_pe #(
        .X(3), .Y(4), .data_width(64), .MY_X(1), .MY_Y(2),
        .numPackets(NPK_A), .rate(RATE_A), .PATTERN(0)
    ) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .enableSend(en_a),
        .r_valid_pe(va), .r_data_pe(da), .r_ready_pe(rdy_a),
        .w_valid_pe(wv_a), .w_data_pe(wd_a), .done(done_a),
        .sentCount(sent_a), .receiveCount(recv_a), .latencySum(sum_a),
        .latencyMax(max_a), .misroute(mis_a)
    );

    traffic_gen_pe #(
        .X(4), .Y(4), .data_width(48), .MY_X(3), .MY_Y(0),
        .numPackets(NPK_B), .rate(RATE_B), .PATTERN(2)
    ) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .enableSend(en_b),
        .r_valid_pe(vb), .r_data_pe(db), .r_ready_pe(rdy_b),
        .w_valid_pe(wv_b), .w_data_pe(wd_b), .done(done_b),
        .sentCount(sent_b), .receiveCount(recv_b), .latencySum(sum_b),
        .latencyMax(max_b), .misroute(mis_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycleCount
    logic [31:0] cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    int unsigned n_cmp, n_bad;

    // Model state
    bit          act_a, dn_a, act_b, dn_b, mis_m;
    int unsigned ka, kb;
    logic [31:0] nv_a, nv_b, rc_m, mx_m;
    logic [15:0] lf_a, lf_b;
    longint unsigned sum_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] seed_of(input int unsigned idx);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(idx);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

    // Random destination on a 3x4 mesh, avoiding self (1,2)
    function automatic logic [67:0] pkt_a(input logic [15:0] lf, input int unsigned seq,
                                          input logic [31:0] ts);
        int unsigned dx, dy;
        dx = int'(lf[1:0]) % 3;
        dy = int'(lf[9:8]) % 4;
        if (dx == 1 && dy == 2) dx = (dx + 1) % 3;
        return (68'(seq % 65536) << 36) | (68'(ts) << 4) | 68'(dy * 4 + dx);
    endfunction

    // Bit-complement of (3,0) on 4x4 is (0,3)
    function automatic logic [51:0] pkt_b(input int unsigned seq, input logic [31:0] ts);
        return (52'(seq % 65536) << 36) | (52'(ts) << 4) | 52'(3 * 4 + 0);
    endfunction

    task automatic fsm_upd(input bit en, input bit rdy, input logic [31:0] c,
                           input int unsigned rt, input int unsigned n,
                           inout bit act, inout bit dn, inout int unsigned k,
                           inout logic [31:0] nv, inout logic [15:0] lf);
        if (dn) begin
            // finished: everything ignored
        end else if (!act) begin
            if (en) begin
                act = 1'b1;
                nv  = c + rt + 1;
            end
        end else if (c >= nv) begin
            if (rdy) begin
                k++;
                lf = lfsr_step(lf);
                if (k == n) begin
                    dn  = 1'b1;
                    act = 1'b0;
                end else if (en) begin
                    nv = c + 1 + rt;
                end else begin
                    act = 1'b0;
                end
            end
        end else if (!en) begin
            act = 1'b0;
        end
    endtask

    task automatic reset_model();
        act_a = 0; dn_a = 0; ka = 0; nv_a = 0; lf_a = seed_of(2 * 3 + 1);
        act_b = 0; dn_b = 0; kb = 0; nv_b = 0; lf_b = seed_of(0 * 4 + 3);
        rc_m = 0; mx_m = 0; sum_m = 0; mis_m = 0;
    endtask

    task automatic chk_zero();
        chk("rst_valid_a", va, 0);     chk("rst_data_a", da, 0);
        chk("rst_done_a", done_a, 0);  chk("rst_sent_a", sent_a, 0);
        chk("rst_recv_a", recv_a, 0);  chk("rst_sum_a", sum_a, 0);
        chk("rst_max_a", max_a, 0);    chk("rst_mis_a", mis_a, 0);
        chk("rst_valid_b", vb, 0);     chk("rst_data_b", db, 0);
        chk("rst_done_b", done_b, 0);  chk("rst_sent_b", sent_b, 0);
    endtask

    // mode: 0 random receive, 1 directed receive (lat_req, self), 2 none, 3 wrong dest
    task automatic step(input int mode, input logic [31:0] lat_req);
        logic [31:0] c, ts, lat;
        logic [3:0]  dst;
        bit          ev_a, ev_b;
        @(negedge clk);
        c    = cyc;
        ev_a = act_a && c >= nv_a;
        ev_b = act_b && c >= nv_b;
        chk("valid_a", va, ev_a);
        chk("done_a", done_a, dn_a);
        chk("sent_a", sent_a, ka);
        if (ev_a) chk("data_a", da, pkt_a(lf_a, ka, nv_a));
        chk("valid_b", vb, ev_b);
        chk("done_b", done_b, dn_b);
        chk("sent_b", sent_b, kb);
        if (ev_b) chk("data_b", db, pkt_b(kb, nv_b));
        chk("recv_a", recv_a, rc_m);
        chk("lsum_a", sum_a, sum_m);
        chk("lmax_a", max_a, mx_m);
        chk("misroute_a", mis_a, mis_m);

        rdy_a = 1'($urandom_range(0, 1));
        en_a  = ($urandom_range(0, 9) != 0);
        rdy_b = 1'b1;
        en_b  = 1'b1;

        dst = SELF_A;
        if ($urandom_range(0, 19) == 0) ts = c + $urandom_range(1, 5);
        else                            ts = c - $urandom_range(0, 300);
        unique case (mode)
            0: wv_a = ($urandom_range(0, 3) == 0);
            1: begin wv_a = 1'b1; ts = c - lat_req; end
            3: begin wv_a = 1'b1; dst = 4'd0; end
            default: wv_a = 1'b0;
        endcase
        wd_a = (68'($urandom_range(0, 65535)) << 36) | (68'(ts) << 4) | 68'(dst);
        if (wv_a) begin
            if (rc_m != 32'hFFFF_FFFF) rc_m++;
            lat   = c - ts;
            sum_m = (sum_m + lat > SUM_MAX) ? SUM_MAX : sum_m + lat;
            if (lat > mx_m) mx_m = lat;
            if (dst != SELF_A) mis_m = 1'b1;
        end

        fsm_upd(en_a, rdy_a, c, RATE_A, NPK_A, act_a, dn_a, ka, nv_a, lf_a);
        fsm_upd(en_b, rdy_b, c, RATE_B, NPK_B, act_b, dn_b, kb, nv_b, lf_b);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rstn = 1'b0; start = 1'b0;
        en_a = 0; rdy_a = 0; wv_a = 0; wd_a = '0;
        en_b = 0; rdy_b = 0; wv_b = 0; wd_b = '0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero();
        #2 rstn = 1'b1;
        start = 1'b1;

        // Two directed deliveries: latencies 10 and 3
        step(1, 32'd10);
        step(1, 32'd3);
        step(2, 32'd0);
        chk("dir_recv", recv_a, 32'd2);
        chk("dir_sum", sum_a, 48'd13);
        chk("dir_max", max_a, 32'd10);

        // Run until packet 2 of dut_a is about to be offered
        for (int i = 0; i < 3000; i++) begin
            step(0, 32'd0);
            if (act_a && ka == 2 && cyc + 1 >= nv_a) break;
        end
        @(negedge clk);
        chk("pre_rst_valid_a", va, 1'b1);
        chk("pre_rst_sent_a", sent_a, 32'd2);
        #1 rstn = 1'b0;
        wv_a = 0; en_a = 0; en_b = 0;
        #1 chk_zero();
        reset_model();
        @(posedge clk);
        @(negedge clk);
        chk_zero();
        #2 rstn = 1'b1;

        // Full run after reset: destinations restart from the seed
        for (int i = 0; i < 30000; i++) begin
            step(0, 32'd0);
            if (dn_a && dn_b) break;
        end
        repeat (8) step(0, 32'd0);
        chk("final_done_a", done_a, 1'b1);
        chk("final_sent_a", sent_a, NPK_A);
        chk("final_done_b", done_b, 1'b1);
        chk("final_sent_b", sent_b, NPK_B);
        chk("pre_mis_a", mis_a, 1'b0);

        step(3, 32'd0);
        step(2, 32'd0);
        chk("misroute_set", mis_a, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
